// File: rtl/sensor_uart_reporter_pkg.sv
// sensor_uart_reporter_pkg: shared ASCII constants, frame lengths, FSM encoding and helpers
package sensor_uart_reporter_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, CONV, SEND} stateT;

    localparam int BIN_WIDTH = 9;
    localparam int DIST_LEN  = 9;
    localparam int DHT_LEN   = 13;

    localparam logic [7:0] SAT_LIMIT = 8'd99;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_DASH = 8'h2D;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_D    = 8'h44;
    localparam logic [7:0] ASCII_T    = 8'h54;
    localparam logic [7:0] ASCII_H    = 8'h48;
    localparam logic [7:0] ASCII_C    = 8'h43;
    localparam logic [7:0] ASCII_PCT  = 8'h25;
    localparam logic [7:0] ASCII_EQ   = 8'h3D;
    localparam logic [7:0] ASCII_LC_C = 8'h63;
    localparam logic [7:0] ASCII_LC_M = 8'h6D;
    localparam logic [7:0] ASCII_SP   = 8'h20;

    function automatic logic [7:0] sat99(input logic [7:0] v);
        return (v > SAT_LIMIT) ? SAT_LIMIT : v;
    endfunction

    function automatic logic [7:0] digitChar(input logic [3:0] d);
        return ASCII_ZERO + {4'h0, d};
    endfunction

endpackage

// File: rtl/sensor_uart_reporter_bcd_conv.sv
// bcd_conv: sequential double-dabble, one input bit per cycle, 9-bit binary to three BCD digits
module bcd_conv
    import sensor_uart_reporter_pkg::*;
(
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 iStart,
    input  logic [BIN_WIDTH-1:0] iBin,
    output logic                 oDone,
    output logic [11:0]          oBcd
);

    logic [BIN_WIDTH-1:0] binReg;
    logic [3:0]           cnt;
    logic [11:0]          adj;

    // Add-3 correction on every digit that would overflow past 9 when doubled
    always_comb begin
        adj[3:0]   = (oBcd[3:0]   >= 4'd5) ? oBcd[3:0]   + 4'd3 : oBcd[3:0];
        adj[7:4]   = (oBcd[7:4]   >= 4'd5) ? oBcd[7:4]   + 4'd3 : oBcd[7:4];
        adj[11:8]  = (oBcd[11:8]  >= 4'd5) ? oBcd[11:8]  + 4'd3 : oBcd[11:8];
    end

    // oDone marks the cycle whose clock edge completes the final shift
    assign oDone = (cnt == 4'd1);

    // Load on start, then shift one binary bit into the BCD register per cycle
    always_ff @(posedge iClk) begin
        if (iRst) begin
            binReg <= '0;
            oBcd   <= '0;
            cnt    <= '0;
        end else if (iStart) begin
            binReg <= iBin;
            oBcd   <= '0;
            cnt    <= 4'(BIN_WIDTH);
        end else if (cnt != 4'd0) begin
            {oBcd, binReg} <= {adj, binReg} << 1;
            cnt            <= cnt - 4'd1;
        end
    end

endmodule

// File: rtl/sensor_uart_reporter.sv
// sensor_uart_reporter: formats distance / DHT readings into ASCII frames for the UART TX FIFO
// Optional periodic auto-report: define SENSOR_REPORT_PERIODIC_EN
module sensor_uart_reporter
    import sensor_uart_reporter_pkg::*;
#(
    parameter int CLK_HZ           = 100_000_000,
    parameter int REPORT_PERIOD_MS = 1000
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iReq_Dist,
    input  logic       iReq_DHT,
    input  logic [8:0] iDist,
    input  logic [7:0] iTemp,
    input  logic [7:0] iHumid,
    input  logic       iDHT_Valid,
    input  logic       iTx_Full,
    output logic       oTx_Push,
    output logic [7:0] oTx_Data,
    output logic       oBusy
);

    if (CLK_HZ / 1000 * REPORT_PERIOD_MS < 1) begin : gBadPeriod
        $error("report period must span at least one clock cycle");
    end

    stateT                state, stateNext;
    logic                 pendDist, pendDht, owedDht;
    logic                 isDht, phase;
    logic [3:0]           idx;
    logic [7:0]           tempBcd, humidSnap;
    logic                 validSnap;
    logic                 tick, reqDist, reqDht, anyDist, anyDht, pickDht;
    logic                 clrDist, clrDht, lastByte, convDone;
    logic [BIN_WIDTH-1:0] convIn;
    logic [11:0]          convBcd;
    logic [7:0]           frameByte, t1, t0, h1, h0;

`ifdef SENSOR_REPORT_PERIODIC_EN
    localparam int PERIOD = CLK_HZ / 1000 * REPORT_PERIOD_MS;
    logic [31:0] timer;

    assign tick = (timer == 32'(PERIOD - 1));

    // Free-running report timer, unaffected by frame activity
    always_ff @(posedge iClk) begin
        if (iRst) timer <= '0;
        else      timer <= tick ? '0 : timer + 32'd1;
    end
`else
    assign tick = 1'b0;
`endif

    assign reqDist  = iReq_Dist | tick;
    assign reqDht   = iReq_DHT | tick;
    assign anyDist  = pendDist | reqDist;
    assign anyDht   = pendDht | reqDht;
    // A DHT request already pending when a distance frame started goes before a newer distance request
    assign pickDht  = anyDht && (owedDht || !anyDist);
    assign clrDist  = (state == IDLE) && anyDist && !pickDht;
    assign clrDht   = (state == IDLE) && pickDht;
    assign lastByte = idx == (isDht ? 4'(DHT_LEN - 1) : 4'(DIST_LEN - 1));
    assign convIn   = !isDht ? iDist : {1'b0, phase ? humidSnap : sat99(iTemp)};
    assign oTx_Push = (state == SEND) && !iTx_Full;
    assign oTx_Data = oTx_Push ? frameByte : 8'h00;
    assign oBusy    = (state != IDLE);

    bcd_conv uConv (
        .iClk  (iClk),
        .iRst  (iRst),
        .iStart(state == LOAD),
        .iBin  (convIn),
        .oDone (convDone),
        .oBcd  (convBcd)
    );

    // State register
    always_ff @(posedge iClk) begin
        if (iRst) state <= IDLE;
        else      state <= stateNext;
    end

    // Next-state logic; DHT frames convert temperature then humidity
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    stateNext = (anyDist || anyDht) ? LOAD : IDLE;
            LOAD:    stateNext = CONV;
            CONV:    stateNext = !convDone ? CONV : (isDht && !phase) ? LOAD : SEND;
            SEND:    stateNext = (oTx_Push && lastByte) ? IDLE : SEND;
            default: stateNext = IDLE;
        endcase
    end

    // Pending flags, frame selection, input snapshots and byte index
    always_ff @(posedge iClk) begin
        if (iRst) begin
            pendDist  <= 1'b0;
            pendDht   <= 1'b0;
            owedDht   <= 1'b0;
            isDht     <= 1'b0;
            phase     <= 1'b0;
            idx       <= '0;
            tempBcd   <= '0;
            humidSnap <= '0;
            validSnap <= 1'b0;
        end else begin
            pendDist <= anyDist && !clrDist;
            pendDht  <= anyDht && !clrDht;
            if (clrDist)     owedDht <= anyDht;
            else if (clrDht) owedDht <= 1'b0;
            if (state == IDLE) begin
                isDht <= pickDht;
                phase <= 1'b0;
            end
            if (state == CONV && convDone && isDht && !phase) phase <= 1'b1;
            if (state == LOAD && !phase) begin
                humidSnap <= sat99(iHumid);
                validSnap <= iDHT_Valid;
            end
            if (state == LOAD && phase) tempBcd <= convBcd[7:0];
            idx <= (state != SEND) ? '0 : oTx_Push ? idx + 4'd1 : idx;
        end
    end

    assign t1 = validSnap ? digitChar(tempBcd[7:4]) : ASCII_DASH;
    assign t0 = validSnap ? digitChar(tempBcd[3:0]) : ASCII_DASH;
    assign h1 = validSnap ? digitChar(convBcd[7:4]) : ASCII_DASH;
    assign h0 = validSnap ? digitChar(convBcd[3:0]) : ASCII_DASH;

    // Byte selection for the frame currently being sent
    always_comb begin
        frameByte = 8'h00;
        if (!isDht) begin
            case (idx)
                4'd0:    frameByte = ASCII_D;
                4'd1:    frameByte = ASCII_EQ;
                4'd2:    frameByte = digitChar(convBcd[11:8]);
                4'd3:    frameByte = digitChar(convBcd[7:4]);
                4'd4:    frameByte = digitChar(convBcd[3:0]);
                4'd5:    frameByte = ASCII_LC_C;
                4'd6:    frameByte = ASCII_LC_M;
                4'd7:    frameByte = ASCII_CR;
                4'd8:    frameByte = ASCII_LF;
                default: frameByte = 8'h00;
            endcase
        end else begin
            case (idx)
                4'd0:    frameByte = ASCII_T;
                4'd1:    frameByte = ASCII_EQ;
                4'd2:    frameByte = t1;
                4'd3:    frameByte = t0;
                4'd4:    frameByte = ASCII_C;
                4'd5:    frameByte = ASCII_SP;
                4'd6:    frameByte = ASCII_H;
                4'd7:    frameByte = ASCII_EQ;
                4'd8:    frameByte = h1;
                4'd9:    frameByte = h0;
                4'd10:   frameByte = ASCII_PCT;
                4'd11:   frameByte = ASCII_CR;
                4'd12:   frameByte = ASCII_LF;
                default: frameByte = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_sensor_uart_reporter.sv
// tb_sensor_uart_reporter: directed + randomized checks of frame content, latency, stalls, ordering and reset
module tb_sensor_uart_reporter;

    logic       iClk = 1'b0;
    logic       iRst = 1'b1;
    logic       iReq_Dist = 1'b0;
    logic       iReq_DHT = 1'b0;
    logic [8:0] iDist = '0;
    logic [7:0] iTemp = '0;
    logic [7:0] iHumid = '0;
    logic       iDHT_Valid = 1'b0;
    logic       iTx_Full = 1'b0;
    logic       oTx_Push;
    logic [7:0] oTx_Data;
    logic       oBusy;

    sensor_uart_reporter dut (
        .iClk      (iClk),
        .iRst      (iRst),
        .iReq_Dist (iReq_Dist),
        .iReq_DHT  (iReq_DHT),
        .iDist     (iDist),
        .iTemp     (iTemp),
        .iHumid    (iHumid),
        .iDHT_Valid(iDHT_Valid),
        .iTx_Full  (iTx_Full),
        .oTx_Push  (oTx_Push),
        .oTx_Data  (oTx_Data),
        .oBusy     (oBusy)
    );

    always #5 iClk = ~iClk;

    int cyc = 0;
    always @(posedge iClk) cyc <= cyc + 1;

    logic [7:0] gotByte[$];
    int         gotCyc[$];
    logic [7:0] expByte[$];
    int         total = 0;
    int         fails = 0;
    int         t0 = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Capture every pushed byte with its cycle number; push must never coincide with full, data must idle at zero
    always @(negedge iClk) begin
        chk("push_while_full", int'(oTx_Push && iTx_Full), 0);
        chk("data_idle_zero", oTx_Push ? 0 : int'(oTx_Data), 0);
        if (oTx_Push === 1'b1) begin
            gotByte.push_back(oTx_Data);
            gotCyc.push_back(cyc);
        end
    end

    function automatic logic [7:0] dig(input int v);
        return 8'(48 + v);
    endfunction

    function automatic void expDist(input int d);
        expByte.push_back("D"); expByte.push_back("=");
        expByte.push_back(dig(d / 100)); expByte.push_back(dig(d / 10 % 10)); expByte.push_back(dig(d % 10));
        expByte.push_back("c"); expByte.push_back("m"); expByte.push_back(8'h0D); expByte.push_back(8'h0A);
    endfunction

    function automatic void expDht(input int t, input int h, input bit v);
        int ts = (t > 99) ? 99 : t;
        int hs = (h > 99) ? 99 : h;
        expByte.push_back("T"); expByte.push_back("=");
        expByte.push_back(v ? dig(ts / 10) : "-"); expByte.push_back(v ? dig(ts % 10) : "-");
        expByte.push_back("C"); expByte.push_back(" "); expByte.push_back("H"); expByte.push_back("=");
        expByte.push_back(v ? dig(hs / 10) : "-"); expByte.push_back(v ? dig(hs % 10) : "-");
        expByte.push_back("%"); expByte.push_back(8'h0D); expByte.push_back(8'h0A);
    endfunction

    function automatic int relCyc(input int i);
        return (i < gotCyc.size()) ? gotCyc[i] - t0 : -1;
    endfunction

    task automatic clearQ();
        gotByte.delete(); gotCyc.delete(); expByte.delete();
    endtask

    task automatic compareStream(input string tag);
        chk({tag, "_count"}, gotByte.size(), expByte.size());
        for (int i = 0; i < expByte.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), (i < gotByte.size()) ? int'(gotByte[i]) : -1, int'(expByte[i]));
    endtask

    task automatic pulse(input bit d, input bit h);
        @(posedge iClk); #1;
        iReq_Dist = d; iReq_DHT = h; t0 = cyc;
        @(posedge iClk); #1;
        iReq_Dist = 1'b0; iReq_DHT = 1'b0;
    endtask

    task automatic goPos(input int c);
        while (cyc < c) begin @(posedge iClk); #1; end
    endtask

    task automatic goNeg(input int c);
        goPos(c);
        @(negedge iClk);
    endtask

    task automatic waitPushes(input int n, input int budget);
        int k = 0;
        while (gotByte.size() < n && k < budget) begin @(negedge iClk); k++; end
        chk("push_budget", int'(gotByte.size() >= n), 1);
    endtask

    task automatic waitIdle();
        int k = 0;
        while (oBusy !== 1'b0 && k < 100) begin @(negedge iClk); k++; end
        chk("return_idle", int'(oBusy), 0);
        repeat (3) @(posedge iClk);
        #1;
    endtask

    initial begin
        int d, d2, t, h;
        bit v;
        repeat (3) @(posedge iClk);
        #1; iRst = 1'b0;
        @(negedge iClk);
        chk("rst_push", int'(oTx_Push), 0);
        chk("rst_data", int'(oTx_Data), 0);
        chk("rst_busy", int'(oBusy), 0);

        // Distance 123, exact latency and busy window
        iDist = 9'd123; clearQ(); expDist(123);
        pulse(1, 0);
        goNeg(t0 + 19); chk("dist_busy_c19", int'(oBusy), 1);
        goNeg(t0 + 20); chk("dist_busy_c20", int'(oBusy), 0);
        waitPushes(9, 5); compareStream("dist123");
        chk("dist_first_push", relCyc(0), 11);
        chk("dist_last_push", relCyc(8), 19);
        waitIdle();

        // DHT 25/40 valid
        iTemp = 8'd25; iHumid = 8'd40; iDHT_Valid = 1'b1; clearQ(); expDht(25, 40, 1);
        pulse(0, 1);
        waitPushes(13, 60); compareStream("dht25_40");
        chk("dht_first_push", relCyc(0), 21);
        chk("dht_last_push", relCyc(12), 33);
        goNeg(t0 + 34); chk("dht_busy_c34", int'(oBusy), 0);
        waitIdle();

        // Temperature saturation
        h = $urandom_range(0, 255);
        iTemp = 8'd130; iHumid = 8'(h); clearQ(); expDht(130, h, 1);
        pulse(0, 1);
        waitPushes(13, 60); compareStream("dht_sat");
        waitIdle();

        // Invalid checksum gives dashes with unchanged latency
        t = $urandom_range(0, 255); h = $urandom_range(0, 255);
        iTemp = 8'(t); iHumid = 8'(h); iDHT_Valid = 1'b0; clearQ(); expDht(t, h, 0);
        pulse(0, 1);
        waitPushes(13, 60); compareStream("dht_invalid");
        chk("dht_invalid_first_push", relCyc(0), 21);
        waitIdle();

        // Random distances with random FIFO-full stalls and input scrambling after the snapshot
        for (int n = 0; n < 4; n++) begin
            int k = 0;
            d = $urandom_range(0, 511);
            iDist = 9'(d); clearQ(); expDist(d);
            pulse(1, 0);
            goPos(t0 + 2); iDist = 9'($urandom);
            while (gotByte.size() < 9 && k < 300) begin
                @(posedge iClk); #1;
                iTx_Full = ($urandom_range(0, 2) == 0);
                k++;
            end
            iTx_Full = 1'b0;
            waitPushes(9, 5); compareStream($sformatf("dist_rand%0d", n));
            waitIdle();
        end

        // Five-cycle stall after the third byte
        d = $urandom_range(0, 511);
        iDist = 9'(d); clearQ(); expDist(d);
        pulse(1, 0);
        goPos(t0 + 14); iTx_Full = 1'b1;
        goPos(t0 + 19); iTx_Full = 1'b0;
        waitPushes(9, 30); compareStream("dist_stall");
        chk("stall_third_push", relCyc(2), 13);
        chk("stall_fourth_push", relCyc(3), 19);
        chk("stall_last_push", relCyc(8), 24);
        waitIdle();

        // Random DHT frames, inputs scrambled once both snapshots are taken
        for (int n = 0; n < 3; n++) begin
            t = $urandom_range(0, 255); h = $urandom_range(0, 255); v = 1'($urandom);
            iTemp = 8'(t); iHumid = 8'(h); iDHT_Valid = v; clearQ(); expDht(t, h, v);
            pulse(0, 1);
            goPos(t0 + 12);
            iTemp = 8'($urandom); iHumid = 8'($urandom); iDHT_Valid = 1'($urandom);
            waitPushes(13, 60); compareStream($sformatf("dht_rand%0d", n));
            chk("dht_rand_first_push", relCyc(0), 21);
            waitIdle();
        end

        // Simultaneous requests then repeated distance requests during SEND: order D, T, D
        d = $urandom_range(0, 511); d2 = $urandom_range(0, 511);
        t = $urandom_range(0, 99); h = $urandom_range(0, 99);
        iDist = 9'(d); iTemp = 8'(t); iHumid = 8'(h); iDHT_Valid = 1'b1; clearQ();
        expDist(d); expDht(t, h, 1); expDist(d2);
        pulse(1, 1);
        goPos(t0 + 15); iDist = 9'(d2); iReq_Dist = 1'b1;
        @(posedge iClk); #1; iReq_Dist = 1'b0;
        goPos(t0 + 17); iReq_Dist = 1'b1;
        @(posedge iClk); #1; iReq_Dist = 1'b0;
        waitPushes(31, 120);
        repeat (40) @(negedge iClk);
        compareStream("order_dtd");
        chk("order_dht_first_push", relCyc(9), 41);
        chk("order_dist2_first_push", relCyc(22), 65);
        waitIdle();

        // Reset after the fourth DHT byte aborts the frame and drops a pending distance request
        t = $urandom_range(0, 255); h = $urandom_range(0, 255);
        iTemp = 8'(t); iHumid = 8'(h); iDHT_Valid = 1'b1; clearQ(); expDht(t, h, 1);
        pulse(0, 1);
        goPos(t0 + 22); iReq_Dist = 1'b1;
        @(posedge iClk); #1; iReq_Dist = 1'b0;
        goNeg(t0 + 24); #1; iRst = 1'b1;
        goNeg(t0 + 25);
        chk("rst_mid_push", int'(oTx_Push), 0);
        chk("rst_mid_busy", int'(oBusy), 0);
        goPos(t0 + 27); iRst = 1'b0;
        repeat (60) @(negedge iClk);
        chk("rst_abort_count", gotByte.size(), 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("rst_abort_byte%0d", i), (i < gotByte.size()) ? int'(gotByte[i]) : -1, int'(expByte[i]));
        chk("rst_abort_idle", int'(oBusy), 0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d checks made", total);
        $fatal(1, "watchdog expired");
    end

endmodule
